// File: rtl/lvds_pkg.sv
// Shared constants for the 4-lane DDR I/Q LVDS link (transmit and receive sides).
package lvds_pkg;

  // Default word width and the frame geometry derived from it.
  localparam int WORDWIDTH_DEF   = 12;
  localparam int SLOTS           = WORDWIDTH_DEF / 2;
  localparam int FCLK_HIGH_SLOTS = SLOTS / 2;

  // Lane indices, identical on both ends of the link.
  localparam int NUM_LANES = 4;
  localparam int DR0       = 0;
  localparam int DR1       = 1;
  localparam int DI0       = 2;
  localparam int DI1       = 3;

  // Clock cycles per frame for a given word width (two bits per lane per DCLK period).
  function automatic int slots_of(input int wordwidth);
    return wordwidth / 2;
  endfunction

endpackage

// File: rtl/lvds_tx_lane.sv
// One serial data lane: parallel load on the frame load edge, LSB-first shift out.
module lvds_tx_lane #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic         bit_o
);

  logic [W-1:0] sh_q, sh_d;
  logic         bit_q, bit_d;

  // Next state: a load presents bit 0 immediately and keeps the rest for later slots.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    sh_d  = sh_q >> 1;
    bit_d = sh_q[0];
    if (load_i) begin
      sh_d  = data_i >> 1;
      bit_d = data_i[0];
    end
  end

  // Shift register and registered lane output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      sh_q  <= '0;
      bit_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bit_q <= bit_d;
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/lvds_tx.sv
// Fabric LVDS source-synchronous serializer: one R/I pair per frame on four DDR lanes
// with bit clock and frame clock, fed through a one-entry valid/ready buffer.
module lvds_tx
  import lvds_pkg::*;
#(
  parameter int                   WORDWIDTH = WORDWIDTH_DEF,
  parameter logic [WORDWIDTH-1:0] IDLE_R    = '0,
  parameter logic [WORDWIDTH-1:0] IDLE_I    = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WORDWIDTH-1:0] i_data_R,
  input  logic [WORDWIDTH-1:0] i_data_I,
  output logic                 o_lvds_dclk,
  output logic                 o_lvds_fclk,
  output logic                 o_lvds_dr0,
  output logic                 o_lvds_dr1,
  output logic                 o_lvds_di0,
  output logic                 o_lvds_di1,
  output logic                 o_frame_start,
  output logic                 o_underrun
);

  localparam int              NSLOTS    = slots_of(WORDWIDTH);
  localparam int              HALF      = WORDWIDTH / 2;
  localparam int              FCLK_HI   = NSLOTS / 2;
  localparam int              SW        = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam logic [SW-1:0]   LAST_SLOT = SW'(NSLOTS - 1);

  // Slot counter and registered clock/flag outputs.
  logic [SW-1:0] slot_q, slot_d;
  logic          dclk_q, dclk_d;
  logic          fclk_q, fclk_d;
  logic          fs_q, fs_d;
  logic          ur_q, ur_d;

  // One-entry holding buffer.
  logic                 full_q, full_d;
  logic [WORDWIDTH-1:0] hold_r_q, hold_i_q;

  logic                 load;
  logic                 handshake;
  logic                 take_held;
  logic [WORDWIDTH-1:0] word_r, word_i;
  logic [HALF-1:0]      lane_word [NUM_LANES];
  logic [NUM_LANES-1:0] lane_bit;

  assign load      = (slot_q == LAST_SLOT);
  assign handshake = i_valid & ~full_q;
  assign take_held = load & i_en & full_q;
  assign o_ready   = ~full_q;

  // Frame sequencing: next slot, clocks for that slot, buffer flag and load-edge pulses.
  always_comb begin
    slot_d = load ? '0 : slot_q + 1'b1;
    dclk_d = slot_d[0];
    fclk_d = (slot_d < SW'(FCLK_HI));
    fs_d   = load;
    ur_d   = load & i_en & ~full_q;
    full_d = full_q;
    if (take_held) begin
      full_d = 1'b0;
    end else if (handshake) begin
      // A handshake on an empty load edge only fills the buffer; there is no bypass.
      full_d = 1'b1;
    end
  end

  // Word presented to the lanes on the load edge, split into per-lane halves.
  always_comb begin
    word_r = take_held ? hold_r_q : IDLE_R;
    word_i = take_held ? hold_i_q : IDLE_I;
    lane_word[DR0] = word_r[HALF-1:0];
    lane_word[DR1] = word_r[WORDWIDTH-1:HALF];
    lane_word[DI0] = word_i[HALF-1:0];
    lane_word[DI1] = word_i[WORDWIDTH-1:HALF];
  end

  // Control state; the counter resets to the last slot so the first edge enters slot 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q <= LAST_SLOT;
      dclk_q <= 1'b0;
      fclk_q <= 1'b0;
      fs_q   <= 1'b0;
      ur_q   <= 1'b0;
      full_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      dclk_q <= dclk_d;
      fclk_q <= fclk_d;
      fs_q   <= fs_d;
      ur_q   <= ur_d;
      full_q <= full_d;
    end
  end

  // Holding register payload, captured on a handshake.
  always_ff @(posedge i_clk) begin
    // NOTE: payload has no reset; full_q alone decides whether it is meaningful.
    if (handshake) begin
      hold_r_q <= i_data_R;
      hold_i_q <= i_data_I;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lvds_tx_lane #(.W(HALF)) u_lane (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .load_i (load),
      .data_i (lane_word[g]),
      .bit_o  (lane_bit[g])
    );
  end

  assign o_lvds_dclk   = dclk_q;
  assign o_lvds_fclk   = fclk_q;
  assign o_lvds_dr0    = lane_bit[DR0];
  assign o_lvds_dr1    = lane_bit[DR1];
  assign o_lvds_di0    = lane_bit[DI0];
  assign o_lvds_di1    = lane_bit[DI1];
  assign o_frame_start = fs_q;
  assign o_underrun    = ur_q;

endmodule

// File: tb/tb_lvds_tx.sv
// Directed bench for lvds_tx: a cycle table for one sample frame plus corner-case sequences.
module tb_lvds_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [11:0] data_r = '0;
  logic [11:0] data_i = '0;
  logic        ready, dclk, fclk, dr0, dr1, di0, di1, fs, ur;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lvds_tx #(.WORDWIDTH(12), .IDLE_R(12'h000), .IDLE_I(12'h000)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_valid       (valid),
    .o_ready       (ready),
    .i_data_R      (data_r),
    .i_data_I      (data_i),
    .o_lvds_dclk   (dclk),
    .o_lvds_fclk   (fclk),
    .o_lvds_dr0    (dr0),
    .o_lvds_dr1    (dr1),
    .o_lvds_di0    (di0),
    .o_lvds_di1    (di1),
    .o_frame_start (fs),
    .o_underrun    (ur)
  );

  // Output vector order: {dclk, fclk, dr0, dr1, di0, di1, frame_start, underrun, ready}
  function automatic logic [8:0] act_vec();
    return {dclk, fclk, dr0, dr1, di0, di1, fs, ur, ready};
  endfunction

  // Expected outputs for a slot carrying words r/i, derived from the lane mapping.
  function automatic logic [8:0] exp_vec(input int slot, input logic [11:0] r,
                                         input logic [11:0] i, input logic u, input logic rdy);
    return {slot[0], (slot < 3), r[slot], r[6 + slot], i[slot], i[6 + slot], (slot == 0), u, rdy};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (dclk fclk dr0 dr1 di0 di1 fs ur rdy)", name, act, exp);
    end
  endtask

  // Advance one clock edge and compare the registered outputs 1 ns later.
  task automatic cyc(input string name, input int slot, input logic [11:0] r,
                     input logic [11:0] i, input logic u, input logic rdy);
    @(posedge clk);
    #1;
    check($sformatf("%s slot%0d", name, slot), act_vec(), exp_vec(slot, r, i, u, rdy));
  endtask

  // Assert reset, verify reset outputs, release so the next edge enters slot 0.
  task automatic do_reset(input string name, input logic en_v);
    rst_n = 1'b0;
    valid = 1'b0;
    en    = en_v;
    #2;
    check({name, " reset"}, act_vec(), 9'b0_0_0000_0_0_1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic        valid;
    logic [11:0] r;
    logic [11:0] i;
    logic [8:0]  exp;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] y;
    int          idx;
    logic        rdy_prev;

    // Hand-computed cycles for R=ABC, I=123 accepted in frame 0.
    tbl[0]  = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b0_1_0000_1_1_1};
    tbl[1]  = '{1'b1, 1'b1, 12'hABC, 12'h123, 9'b1_1_0000_0_0_0};
    tbl[2]  = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b0_1_0000_0_0_0};
    tbl[3]  = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b1_0_0000_0_0_0};
    tbl[4]  = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b0_0_0000_0_0_0};
    tbl[5]  = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b1_0_0000_0_0_0};
    tbl[6]  = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b0_1_0010_1_0_1};
    tbl[7]  = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b1_1_0110_0_0_1};
    tbl[8]  = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b0_1_1001_0_0_1};
    tbl[9]  = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b1_0_1100_0_0_1};
    tbl[10] = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b0_0_1000_0_0_1};
    tbl[11] = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b1_0_1110_0_0_1};
    tbl[12] = '{1'b1, 1'b0, 12'h000, 12'h000, 9'b0_1_0000_1_1_1};

    // 1: disabled link sends idle frames, never underruns.
    do_reset("idle", 1'b0);
    for (int k = 0; k < 24; k++) cyc("idle", k % 6, 12'h000, 12'h000, 1'b0, 1'b1);

    // 2: table-driven single sample.
    do_reset("table", 1'b1);
    for (int k = 0; k < 13; k++) begin
      en     = tbl[k].en;
      valid  = tbl[k].valid;
      data_r = tbl[k].r;
      data_i = tbl[k].i;
      @(posedge clk);
      #1;
      check($sformatf("table row%0d", k), act_vec(), tbl[k].exp);
    end
    valid = 1'b0;

    // 3: continuous valid with incrementing data; frame f carries sample f-1.
    do_reset("stream", 1'b1);
    idx = 0;
    rdy_prev = 1'b1;
    valid = 1'b1;
    data_r = 12'h801;
    data_i = ~12'h801;
    for (int f = 0; f < 5; f++) begin
      for (int s = 0; s < 6; s++) begin
        logic [11:0] er;
        er = 12'h801 + 12'(((f > 0) ? f - 1 : 0) * 12'h041);
        if (f == 0) cyc($sformatf("stream f%0d", f), s, 12'h000, 12'h000, (s == 0), 1'b0);
        else        cyc($sformatf("stream f%0d", f), s, er, ~er, 1'b0, (s == 0));
        if (rdy_prev) idx++;
        rdy_prev = ready;
        data_r = 12'h801 + 12'(idx * 12'h041);
        data_i = ~data_r;
      end
    end
    valid = 1'b0;

    // 4: valid only on the load edge -> that frame is an underrun, sample in the next.
    do_reset("loadedge", 1'b1);
    for (int s = 0; s < 6; s++) cyc("loadedge f0", s, 12'h000, 12'h000, (s == 0), 1'b1);
    valid = 1'b1; data_r = 12'h5A7; data_i = 12'hC3E;
    cyc("loadedge f1", 0, 12'h000, 12'h000, 1'b1, 1'b0);
    valid = 1'b0; data_r = 12'h000; data_i = 12'h000;
    for (int s = 1; s < 6; s++) cyc("loadedge f1", s, 12'h000, 12'h000, 1'b0, 1'b0);
    for (int s = 0; s < 6; s++) cyc("loadedge f2", s, 12'h5A7, 12'hC3E, 1'b0, 1'b1);

    // 5: disable with the buffer full, sample preserved and sent after re-enable.
    y = 12'h96D;
    do_reset("enable", 1'b1);
    cyc("enable f0", 0, 12'h000, 12'h000, 1'b1, 1'b1);
    valid = 1'b1; data_r = y; data_i = ~y;
    cyc("enable f0", 1, 12'h000, 12'h000, 1'b0, 1'b0);
    valid = 1'b0; data_r = 12'h000; data_i = 12'h000;
    for (int s = 2; s < 6; s++) cyc("enable f0", s, 12'h000, 12'h000, 1'b0, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 12; k++) cyc("enable off", k % 6, 12'h000, 12'h000, 1'b0, 1'b0);
    en = 1'b1;
    for (int s = 0; s < 6; s++) cyc("enable f3", s, y, ~y, 1'b0, 1'b1);
    for (int s = 0; s < 6; s++) cyc("enable f4", s, 12'h000, 12'h000, (s == 0), 1'b1);

    // 6: reset pulse in slot 3 drops the held sample and restarts at slot 0.
    do_reset("midrst", 1'b1);
    cyc("midrst f0", 0, 12'h000, 12'h000, 1'b1, 1'b1);
    valid = 1'b1; data_r = 12'hFFF; data_i = 12'hFFF;
    cyc("midrst f0", 1, 12'h000, 12'h000, 1'b0, 1'b0);
    valid = 1'b0;
    cyc("midrst f0", 2, 12'h000, 12'h000, 1'b0, 1'b0);
    cyc("midrst f0", 3, 12'h000, 12'h000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst async", act_vec(), 9'b0_0_0000_0_0_1);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) cyc("midrst after", k % 6, 12'h000, 12'h000, (k % 6 == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
